// File: rtl/connect4_host.sv
// Host-side driver for the connect4 engine: queues column moves, runs one op/result exchange at a time,
// tracks turn and score, emits one event per move. Optional result watchdog: CONNECT4_HOST_TIMEOUT_EN.
module connect4_host #(
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mv_valid,
  output logic             mv_ready,
  input  logic [2:0]       mv_col,
  input  logic             eng_op_ready,
  output logic             eng_op_valid,
  output logic             eng_op_player_id,
  output logic [2:0]       eng_op_col_id,
  output logic             eng_re_ready,
  input  logic             eng_re_valid,
  input  logic             eng_re_err,
  input  logic             eng_re_is_finished,
  input  logic             eng_re_winner,
  input  logic             eng_re_tie,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [1:0]       ev_code,
  output logic             ev_player,
  output logic             turn,
  output logic [5:0]       move_cnt,
  output logic [CNT_W-1:0] wins0,
  output logic [CNT_W-1:0] wins1,
  output logic [CNT_W-1:0] ties,
  output logic             timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVENT} state_t;

  state_t        state, state_next;
  logic [2:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop, accept, tmo_hit;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [5:0] sat_move(input logic [5:0] v);
    return (v >= 6'd42) ? 6'd42 : v + 6'd1;
  endfunction

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign mv_ready = !full;
  assign push     = mv_valid && !full;
  assign accept   = (state == S_WAIT) && eng_re_valid;

`ifdef CONNECT4_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wait_cnt;
  logic          timeout_q;

  // A result arriving on the limit cycle still wins over the timeout.
  assign tmo_hit = (state == S_WAIT) && !eng_re_valid && (wait_cnt == TW'(TIMEOUT_CYC - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    eng_op_valid = 1'b0;
    eng_re_ready = 1'b0;
    ev_valid     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_op_valid = 1'b1;
        if (eng_op_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        eng_re_ready = 1'b1;
        if (eng_re_valid || tmo_hit) state_next = S_EVENT;
      end
      S_EVENT: begin
        ev_valid = 1'b1;
        if (ev_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= mv_col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      eng_op_col_id    <= 3'd0;
      eng_op_player_id <= 1'b0;
      ev_code          <= 2'd0;
      ev_player        <= 1'b0;
      turn             <= 1'b0;
      move_cnt         <= 6'd0;
      wins0            <= '0;
      wins1            <= '0;
      ties             <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr           <= rd_ptr + PW'(1);
        eng_op_col_id    <= mem[rd_ptr[AW-1:0]];
        eng_op_player_id <= turn;
      end
      // Score and turn advance on the result sample, not on event acceptance.
      if (accept) begin
        if (eng_re_err) begin
          ev_code   <= 2'd1;
          ev_player <= eng_op_player_id;
        end else if (eng_re_is_finished && eng_re_tie) begin
          ev_code   <= 2'd3;
          ev_player <= eng_op_player_id;
          ties      <= sat_cnt(ties);
          turn      <= 1'b0;
          move_cnt  <= 6'd0;
        end else if (eng_re_is_finished) begin
          ev_code   <= 2'd2;
          ev_player <= eng_re_winner;
          if (eng_re_winner) wins1 <= sat_cnt(wins1);
          else               wins0 <= sat_cnt(wins0);
          turn      <= 1'b0;
          move_cnt  <= 6'd0;
        end else begin
          ev_code   <= 2'd0;
          ev_player <= eng_op_player_id;
          turn      <= ~turn;
          move_cnt  <= sat_move(move_cnt);
        end
      end else if (tmo_hit) begin
        ev_code   <= 2'd1;
        ev_player <= eng_op_player_id;
      end
    end
  end

endmodule

// File: tb/tb_connect4_host.sv
// Scoreboard bench for connect4_host: a behavioural engine answers ops from a response queue,
// and a monitor checks every emitted event against the expected-event queue.
module tb_connect4_host;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mv_valid, mv_ready;
  logic [2:0]       mv_col;
  logic             eng_op_ready, eng_op_valid, eng_op_player_id;
  logic [2:0]       eng_op_col_id;
  logic             eng_re_ready, eng_re_valid, eng_re_err, eng_re_is_finished;
  logic             eng_re_winner, eng_re_tie;
  logic             ev_valid, ev_ready;
  logic [1:0]       ev_code;
  logic             ev_player, turn, timeout;
  logic [5:0]       move_cnt;
  logic [CNT_W-1:0] wins0, wins1, ties;

  always #5 clk = ~clk;

  connect4_host #(.FIFO_DEPTH(4), .CNT_W(CNT_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_col(mv_col),
    .eng_op_ready(eng_op_ready), .eng_op_valid(eng_op_valid),
    .eng_op_player_id(eng_op_player_id), .eng_op_col_id(eng_op_col_id),
    .eng_re_ready(eng_re_ready), .eng_re_valid(eng_re_valid), .eng_re_err(eng_re_err),
    .eng_re_is_finished(eng_re_is_finished), .eng_re_winner(eng_re_winner), .eng_re_tie(eng_re_tie),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_player(ev_player),
    .turn(turn), .move_cnt(move_cnt), .wins0(wins0), .wins1(wins1), .ties(ties),
    .timeout(timeout)
  );

  typedef struct packed { logic [1:0] code; logic player; } ev_t;
  typedef struct packed { logic [2:0] col; logic player; } op_t;
  typedef struct packed { logic err; logic fin; logic win; logic tie; logic noresp; } rsp_t;

  ev_t  ev_q[$];
  op_t  op_q[$];
  rsp_t rsp_q[$];

  int   tests = 0;
  int   fails = 0;
  logic hold_op = 1'b0;
  logic m_turn  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic rsp_t mk(input logic err, input logic fin, input logic win,
                              input logic tie, input logic noresp);
    rsp_t r;
    r.err = err; r.fin = fin; r.win = win; r.tie = tie; r.noresp = noresp;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c);
    int n;
    n        = 0;
    mv_col   = c;
    mv_valid = 1'b1;
    while (!mv_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("push_wait_expired", 1, 0);
    tick();
    mv_valid = 1'b0;
  endtask

  // Queue the expected op and event for a move, then push it into the DUT.
  task automatic move(input logic [2:0] c, input rsp_t r);
    ev_t e;
    op_t o;
    o.col = c;
    o.player = m_turn;
    op_q.push_back(o);
    rsp_q.push_back(r);
    if (r.err || r.noresp) begin
      e.code = 2'd1; e.player = m_turn;
    end else if (r.fin && r.tie) begin
      e.code = 2'd3; e.player = m_turn; m_turn = 1'b0;
    end else if (r.fin) begin
      e.code = 2'd2; e.player = r.win; m_turn = 1'b0;
    end else begin
      e.code = 2'd0; e.player = m_turn; m_turn = ~m_turn;
    end
    ev_q.push_back(e);
    push(c);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((ev_q.size() != 0 || op_q.size() != 0 || eng_op_valid || eng_re_ready || ev_valid)
           && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("drain_expired", 1, 0);
    tick();
  endtask

  task automatic chk_reset();
    chk("rst_mv_ready", mv_ready, 1);
    chk("rst_op_valid", eng_op_valid, 0);
    chk("rst_op_player", eng_op_player_id, 0);
    chk("rst_op_col", eng_op_col_id, 0);
    chk("rst_re_ready", eng_re_ready, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_code", ev_code, 0);
    chk("rst_ev_player", ev_player, 0);
    chk("rst_turn", turn, 0);
    chk("rst_move_cnt", move_cnt, 0);
    chk("rst_wins0", wins0, 0);
    chk("rst_wins1", wins1, 0);
    chk("rst_ties", ties, 0);
    chk("rst_timeout", timeout, 0);
  endtask

  // Behavioural engine: accepts ops, answers two cycles later from the response queue.
  int   es = 0;
  int   dly = 0;
  rsp_t cur;
  op_t  got_op;

  initial begin
    eng_op_ready = 1'b0;
    eng_re_valid = 1'b0;
    eng_re_err = 1'b0; eng_re_is_finished = 1'b0; eng_re_winner = 1'b0; eng_re_tie = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        es = 0;
        eng_op_ready = 1'b0;
        eng_re_valid = 1'b0;
      end else begin
        eng_op_ready = !hold_op;
        if (es == 0) begin
          if (eng_op_valid && eng_op_ready) begin
            if (op_q.size() == 0) chk("op_unexpected", 1, 0);
            else begin
              got_op = op_q.pop_front();
              chk("op_col", eng_op_col_id, got_op.col);
              chk("op_player", eng_op_player_id, got_op.player);
            end
            cur = (rsp_q.size() == 0) ? rsp_t'('0) : rsp_q.pop_front();
            dly = 2;
            es  = 1;
          end
        end else if (es == 1) begin
          if (dly > 0) dly--;
          else if (cur.noresp) es = 0;
          else begin
            eng_re_valid       = 1'b1;
            eng_re_err         = cur.err;
            eng_re_is_finished = cur.fin;
            eng_re_winner      = cur.win;
            eng_re_tie         = cur.tie;
            es = 2;
          end
        end
        if (es == 2 && eng_re_ready) begin
          @(posedge clk);
          #1;
          eng_re_valid = 1'b0;
          eng_re_err = 1'b0; eng_re_is_finished = 1'b0; eng_re_winner = 1'b0; eng_re_tie = 1'b0;
          es = 0;
        end
      end
    end
  end

  ev_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ev_valid && ev_ready) begin
        if (ev_q.size() == 0) chk("ev_unexpected", 1, 0);
        else begin
          mon_e = ev_q.pop_front();
          chk("ev_code", ev_code, mon_e.code);
          chk("ev_player", ev_player, mon_e.player);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; mv_valid = 1'b0; mv_col = 3'd0; ev_ready = 1'b1;
    repeat (3) tick();
    chk_reset();
    rst_n = 1'b1;
    tick();

    // Illegal moves: engine error, including the out-of-range column 7.
    move(3'd3, mk(1, 0, 0, 0, 0));
    move(3'd7, mk(1, 0, 0, 0, 0));
    drain();
    chk("t2_turn", turn, 0);
    chk("t2_move_cnt", move_cnt, 0);

    move(3'd0, mk(0, 0, 0, 0, 0));
    move(3'd1, mk(0, 0, 0, 0, 0));
    drain();
    chk("t1_turn", turn, 0);
    chk("t1_move_cnt", move_cnt, 2);

    for (int i = 0; i < 6; i++) move(3'(i % 2), mk(0, 0, 0, 0, 0));
    move(3'd0, mk(0, 1, 0, 0, 0));
    drain();
    chk("t3_wins0", wins0, 1);
    chk("t3_wins1", wins1, 0);
    chk("t3_turn", turn, 0);
    chk("t3_move_cnt", move_cnt, 0);

    move(3'd5, mk(0, 1, 1, 0, 0));
    drain();
    chk("w1_wins1", wins1, 1);
    chk("w1_wins0", wins0, 1);
    chk("w1_turn", turn, 0);

    // Back-pressure: engine stalls the first op while the FIFO fills.
    hold_op = 1'b1;
    move(3'd2, mk(0, 0, 0, 0, 0));
    move(3'd3, mk(0, 0, 0, 0, 0));
    move(3'd4, mk(0, 0, 0, 0, 0));
    move(3'd5, mk(0, 0, 0, 0, 0));
    move(3'd6, mk(0, 0, 0, 0, 0));
    chk("t4_full", mv_ready, 0);
    mv_col = 3'd1;
    mv_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_held_ready", mv_ready, 0);
      chk("t4_op_stuck", eng_op_valid, 1);
    end
    mv_valid = 1'b0;
    hold_op = 1'b0;
    move(3'd0, mk(0, 0, 0, 0, 0));
    drain();
    chk("t4_turn", turn, 0);
    chk("t4_move_cnt", move_cnt, 6);

    for (int i = 0; i < 40; i++) move(3'(i % 7), mk(0, 0, 0, 0, 0));
    drain();
    chk("mc_sat", move_cnt, 42);
    chk("mc_sat_turn", turn, 0);

    // Event back-pressure with a second move queued behind it.
    ev_ready = 1'b0;
    move(3'd1, mk(0, 1, 0, 1, 0));
    move(3'd2, mk(0, 1, 0, 1, 0));
    n = 0;
    while (!ev_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t5_ev_seen", ev_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t5_ev_valid", ev_valid, 1);
      chk("t5_ev_code", ev_code, 3);
      chk("t5_ev_player", ev_player, 0);
      chk("t5_no_op", eng_op_valid, 0);
      chk("t5_ties", ties, 1);
      chk("t5_move_cnt", move_cnt, 0);
      tick();
    end
    ev_ready = 1'b1;
    drain();
    chk("t5_ties2", ties, 2);
    for (int i = 0; i < 253; i++) move(3'(i % 7), mk(0, 1, 0, 1, 0));
    drain();
    chk("t5_ties_max", ties, 255);
    move(3'd0, mk(0, 1, 0, 1, 0));
    drain();
    chk("t5_ties_sat", ties, 255);

`ifdef CONNECT4_HOST_TIMEOUT_EN
    move(3'd4, mk(0, 0, 0, 0, 1));
    n = 0;
    while (!(eng_op_valid && eng_op_ready) && n < 100) begin
      tick();
      n++;
    end
    tick();
    n = 0;
    while (!ev_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t6_wait_cycles", n, 16);
    drain();
    chk("t6_timeout", timeout, 1);
    chk("t6_turn", turn, 0);
    chk("t6_move_cnt", move_cnt, 0);
`else
    chk("timeout_tied", timeout, 0);
`endif

    // Reset while an op is outstanding and more moves are queued.
    hold_op = 1'b1;
    push(3'd5);
    push(3'd6);
    n = 0;
    while (!eng_op_valid && n < 50) begin
      tick();
      n++;
    end
    chk("rst_mid_issue", eng_op_valid, 1);
    rst_n = 1'b0;
    tick();
    chk_reset();
    op_q.delete();
    rsp_q.delete();
    ev_q.delete();
    m_turn = 1'b0;
    hold_op = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_fifo_lost", eng_op_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
